// File: rtl/updown_bcd_chain_if.sv
`default_nettype none
// ============================================================================
// Module   : updown_bcd_chain_if
// Brief    : Control/data bundle between button logic and the up/down counter.
// Revision : 1.0 - initial release
// ============================================================================
interface updown_bcd_chain_if #(
    parameter int DIGITS = 2,
    parameter int W      = 4
);
    logic                  en;
    logic                  load;
    logic                  inc;
    logic                  dec;
    logic [DIGITS*W-1:0]   loadin;
    logic [DIGITS*W-1:0]   count;
    logic                  at_max;
    logic                  at_min;
    logic                  carry_out;
    logic                  borrow_out;

    modport master (
        output en, load, inc, dec, loadin,
        input  count, at_max, at_min, carry_out, borrow_out
    );

    modport slave (
        input  en, load, inc, dec, loadin,
        output count, at_max, at_min, carry_out, borrow_out
    );
endinterface
`default_nettype wire

// File: rtl/updown_bcd_chain.sv
`default_nettype none
// ============================================================================
// Module   : updown_bcd_chain
// Brief    : Cascaded multi-digit modulo up/down counter with load, wrap/sat.
// Revision : 1.0 - initial release
// ============================================================================
module updown_bcd_chain #(
    parameter int DIGITS = 2,
    parameter int W      = 4,
    parameter int MOD    = 10,
    parameter int SAT    = 0,
    parameter int EDGE   = 1
) (
    input  wire logic            clk,
    input  wire logic            rst,
    updown_bcd_chain_if.slave    bus
);
    localparam int             c_CW      = DIGITS * W;
    localparam logic [W-1:0]   c_DIG_MAX = W'(MOD - 1);
    localparam logic [W:0]     c_MOD_EXT = (W+1)'(MOD);

    logic [c_CW-1:0] r_count;
    logic [c_CW-1:0] w_count_nxt;
    logic [c_CW-1:0] w_inc_val;
    logic [c_CW-1:0] w_dec_val;
    logic [c_CW-1:0] w_ld_val;
    logic            r_inc_q;
    logic            r_dec_q;
    logic            r_carry;
    logic            r_borrow;
    logic            w_carry_nxt;
    logic            w_borrow_nxt;
    logic [DIGITS:0] w_lo_max;
    logic [DIGITS:0] w_lo_min;
    logic            w_up_req;
    logic            w_dn_req;
    logic            w_up;
    logic            w_dn;
    logic            w_all_max;
    logic            w_all_min;

    assign w_up_req = (EDGE != 0) ? (bus.inc & ~r_inc_q) : bus.inc;
    assign w_dn_req = (EDGE != 0) ? (bus.dec & ~r_dec_q) : bus.dec;
    assign w_up     = bus.en & w_up_req & ~w_dn_req;
    assign w_dn     = bus.en & w_dn_req & ~w_up_req;

    // w_lo_max[i] / w_lo_min[i]: every digit below i is at its max / zero
    assign w_lo_max[0] = 1'b1;
    assign w_lo_min[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [W-1:0] w_dig;
            logic [W-1:0] w_ld_dig;
            logic         w_is_max;
            logic         w_is_min;

            assign w_dig    = r_count[gi*W +: W];
            assign w_ld_dig = bus.loadin[gi*W +: W];
            assign w_is_max = (w_dig == c_DIG_MAX);
            assign w_is_min = (w_dig == '0);

            assign w_lo_max[gi+1] = w_lo_max[gi] & w_is_max;
            assign w_lo_min[gi+1] = w_lo_min[gi] & w_is_min;

            assign w_inc_val[gi*W +: W] = !w_lo_max[gi] ? w_dig :
                                          (w_is_max ? '0 : w_dig + W'(1));
            assign w_dec_val[gi*W +: W] = !w_lo_min[gi] ? w_dig :
                                          (w_is_min ? c_DIG_MAX : w_dig - W'(1));
            assign w_ld_val[gi*W +: W]  = ({1'b0, w_ld_dig} >= c_MOD_EXT) ?
                                          c_DIG_MAX : w_ld_dig;
        end
    endgenerate

    assign w_all_max = w_lo_max[DIGITS];
    assign w_all_min = w_lo_min[DIGITS];

    // In saturate mode a step past either end is simply dropped
    always_comb begin
        w_count_nxt  = r_count;
        w_carry_nxt  = 1'b0;
        w_borrow_nxt = 1'b0;
        if (bus.load) begin
            w_count_nxt = w_ld_val;
        end else if (w_up) begin
            if (!(w_all_max && (SAT != 0))) begin
                w_count_nxt = w_inc_val;
                w_carry_nxt = w_all_max;
            end
        end else if (w_dn) begin
            if (!(w_all_min && (SAT != 0))) begin
                w_count_nxt  = w_dec_val;
                w_borrow_nxt = w_all_min;
            end
        end
    end

    // Edge registers reset high so a request held across reset is not a step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_inc_q  <= 1'b1;
            r_dec_q  <= 1'b1;
        end else begin
            r_count  <= w_count_nxt;
            r_carry  <= w_carry_nxt;
            r_borrow <= w_borrow_nxt;
            r_inc_q  <= bus.inc;
            r_dec_q  <= bus.dec;
        end
    end

    assign bus.count      = r_count;
    assign bus.at_max     = w_all_max;
    assign bus.at_min     = w_all_min;
    assign bus.carry_out  = r_carry;
    assign bus.borrow_out = r_borrow;

endmodule
`default_nettype wire
